seq_codes_100b_parity_check: RTL and testbench

- Receive side of the 100-bit even-parity code. The generator produces the parity bit as the XOR of all 100 data bits.
- This block takes a 100-bit word as serial chunks plus the transmitted parity bit over a val/rdy stream. It reassembles the word, recomputes parity incrementally and flags a mismatch.
- It sits between a narrow link deserializer and a wide consumer. It also keeps a saturating count of errored words for status readout.

---
 rtl/codes_pkg.sv | 20 ++
 rtl/seq_codes_100b_parity_check_if.sv | 26 ++
 rtl/seq_codes_100b_parity_check_parity_accum.sv | 21 ++
 rtl/seq_codes_100b_parity_check.sv | 120 ++++++++++++
 tb/tb_seq_codes_100b_parity_check.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/codes_pkg.sv
// Shared types and constants for the 100-bit even-parity receive path.
package codes_pkg;

  typedef enum logic {
    RECV = 1'b0,
    SEND = 1'b1
  } state_e;

  // Parity bit that makes the XOR of data and parity come out even.
  localparam logic EVEN_PARITY = 1'b0;

  function automatic int calc_nbeats(input int nbits, input int chunk);
    return nbits / chunk;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_codes_100b_parity_check_if.sv
// Beat-in / word-out stream bundle between the link deserializer and the wide consumer.
interface seq_codes_100b_parity_check_if #(
  parameter int NBITS = 100,
  parameter int CHUNK = 10
);

  logic             in_val;
  logic             in_rdy;
  logic [CHUNK-1:0] in_data;
  logic             in_par;
  logic             out_val;
  logic             out_rdy;
  logic [NBITS-1:0] out_data;
  logic             out_err;

  modport master (
    output in_val, in_data, in_par, out_rdy,
    input  in_rdy, out_val, out_data, out_err
  );

  modport slave (
    input  in_val, in_data, in_par, out_rdy,
    output in_rdy, out_val, out_data, out_err
  );

endinterface

// File: rtl/seq_codes_100b_parity_check_parity_accum.sv
// Running XOR register: accumulates one parity bit per beat, clear wins over load.
module parity_accum (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic load,
  input  logic bit_in,
  output logic par
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par <= 1'b0;
    end else if (clear) begin
      par <= 1'b0;
    end else if (load) begin
      par <= par ^ bit_in;
    end
  end

endmodule

// File: rtl/seq_codes_100b_parity_check.sv
// Reassembles NBITS-wide words from CHUNK-wide beats, checks even parity and
// keeps a saturating count of errored words handed to the consumer.
module seq_codes_100b_parity_check
  import codes_pkg::*;
#(
  parameter int NBITS = 100,
  parameter int CHUNK = 10,
  parameter int CNTW  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  seq_codes_100b_parity_check_if.slave bus,
  output logic [CNTW-1:0]      err_count,
  input  logic                 err_clear
);

  // NBITS must be a multiple of CHUNK with at least two beats per word.
  localparam int              NBEATS    = calc_nbeats(NBITS, CHUNK);
  localparam int              BW        = cnt_width(NBEATS);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(NBEATS - 1);
  localparam logic [CNTW-1:0] CNT_MAX   = '1;

  state_e               state_q;
  logic [BW-1:0]        beat_q;
  logic                 in_rdy_q;
  logic                 out_val_q;
  logic                 out_err_q;
  logic [NBITS-1:0]     out_data_q;
  logic [NBITS-CHUNK-1:0] word_q;

  logic                 accept;
  logic                 last_beat;
  logic                 chunk_par;
  logic                 run_par;
  logic                 word_err;
  logic                 handshake;
  logic [CNTW-1:0]      cnt_base;
  logic [CNTW-1:0]      cnt_next;

  assign accept    = bus.in_val & in_rdy_q;
  assign last_beat = (beat_q == LAST_BEAT);
  assign chunk_par = ^bus.in_data;
  assign word_err  = run_par ^ chunk_par ^ bus.in_par ^ EVEN_PARITY;
  assign handshake = out_val_q & bus.out_rdy;

  parity_accum u_parity_accum (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (accept & last_beat),
    .load   (accept),
    .bit_in (chunk_par),
    .par    (run_par)
  );

  // The final beat goes straight into out_data, so only the lower beats are buffered.
  // NOTE: this buffer has no reset on purpose; every slice is written before it is
  // read, and the beat counter reset is what discards a partial word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBEATS - 1; i++) begin
      if (accept && beat_q == BW'(i)) begin
        word_q[i*CHUNK +: CHUNK] <= bus.in_data;
      end
    end
  end

  // Clear is applied first so a coincident errored handshake still lands as 1.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_base = err_clear ? '0 : err_count;
    cnt_next = cnt_base;
    if (handshake && out_err_q && cnt_base != CNT_MAX) begin
      cnt_next = cnt_base + CNTW'(1);
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RECV;
      beat_q     <= '0;
      in_rdy_q   <= 1'b1;
      out_val_q  <= 1'b0;
      out_err_q  <= 1'b0;
      out_data_q <= '0;
      err_count  <= '0;
    end else begin
      err_count <= cnt_next;
      unique case (state_q)
        RECV: begin
          if (accept) begin
            if (last_beat) begin
              out_data_q <= {bus.in_data, word_q};
              out_err_q  <= word_err;
              beat_q     <= '0;
              in_rdy_q   <= 1'b0;
              out_val_q  <= 1'b1;
              state_q    <= SEND;
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        SEND: begin
          if (bus.out_rdy) begin
            in_rdy_q  <= 1'b1;
            out_val_q <= 1'b0;
            state_q   <= RECV;
          end
        end
      endcase
    end
  end

  assign bus.in_rdy   = in_rdy_q;
  assign bus.out_val  = out_val_q;
  assign bus.out_data = out_data_q;
  assign bus.out_err  = out_err_q;

endmodule

// File: tb/tb_seq_codes_100b_parity_check.sv
// Randomized scoreboard bench for the 100-bit parity checker with a word-level reference model.
module tb_seq_codes_100b_parity_check;

  localparam int NBITS   = 100;
  localparam int CHUNK   = 10;
  localparam int CNTW    = 8;
  localparam int NBEATS  = NBITS / CHUNK;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  typedef struct {
    logic [NBITS-1:0] data;
    logic             err;
    int               acc_cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [CNTW-1:0] err_count;
  logic            err_clear;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   model_cnt = 0;
  int   sink_stall = 0;
  int   wait_ctr = 0;
  bit   clear_now = 1'b0;
  bit   clear_on_hs = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_codes_100b_parity_check_if #(.NBITS(NBITS), .CHUNK(CHUNK)) bus ();

  seq_codes_100b_parity_check #(.NBITS(NBITS), .CHUNK(CHUNK), .CNTW(CNTW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .err_count(err_count),
    .err_clear(err_clear)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s @cyc %0d: bound expired", name, cyc);
  endtask

  // Sends the first nb beats of w; a complete word is pushed to the scoreboard.
  task automatic send_beats(input logic [NBITS-1:0] w, input logic par, input int nb, input int gap_max);
    for (int b = 0; b < nb; b++) begin
      int gap;
      int budget;
      bit rdy;
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      bus.in_val  = 1'b0;
      bus.in_data = CHUNK'($urandom);
      repeat (gap) begin @(posedge clk); #1; end
      bus.in_val  = 1'b1;
      bus.in_data = w[b*CHUNK +: CHUNK];
      bus.in_par  = (b == NBEATS - 1) ? par : 1'($urandom);
      budget = 0;
      do begin
        @(negedge clk);
        rdy = bus.in_rdy;
        @(posedge clk); #1;
        budget++;
      end while (!rdy && budget < 200);
      if (!rdy) begin
        fail_now("accept_timeout");
        bus.in_val = 1'b0;
        return;
      end
    end
    if (nb == NBEATS) sb.push_back('{w, (^w) ^ par, cyc});
    bus.in_val  = 1'b0;
    bus.in_data = CHUNK'($urandom);
    bus.in_par  = 1'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || bus.out_val) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 2000) fail_now("drain_timeout");
  endtask

  task automatic cnt_check(input string name, input int exp);
    @(negedge clk);
    check(name, 128'(err_count), 128'(exp));
    @(posedge clk); #1;
  endtask

  function automatic logic [NBITS-1:0] rand_word();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[NBITS-1:0];
  endfunction

  // Consumer: applies out_rdy stalls and schedules err_clear pulses.
  initial begin
    bus.out_rdy = 1'b1;
    err_clear   = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!bus.out_val) begin
        wait_ctr    = 0;
        bus.out_rdy = (sink_stall == 0);
      end else if (wait_ctr < sink_stall) begin
        wait_ctr++;
        bus.out_rdy = 1'b0;
      end else begin
        bus.out_rdy = 1'b1;
      end
      err_clear = 1'b0;
      if (clear_now) begin
        err_clear = 1'b1;
        clear_now = 1'b0;
      end else if (clear_on_hs && bus.out_val && bus.out_rdy) begin
        err_clear   = 1'b1;
        clear_on_hs = 1'b0;
      end
    end
  end

  // Monitor: compares presented words against the scoreboard and tracks the error count.
  initial begin
    logic             prev_val;
    logic [NBITS-1:0] held_data;
    logic             held_err;
    int               nxt;
    exp_t             e;
    prev_val  = 1'b0;
    held_data = '0;
    held_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        prev_val = 1'b0;
      end else begin
        check("err_count", 128'(err_count), 128'(model_cnt));
        check("in_rdy_vs_out_val", 128'(bus.in_rdy), 128'(!bus.out_val));
        if (bus.out_val) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_output");
          end else if (!prev_val) begin
            check("latency", 128'(cyc), 128'(sb[0].acc_cyc));
          end else begin
            check("out_data_stable", 128'(bus.out_data), 128'(held_data));
            check("out_err_stable", 128'(bus.out_err), 128'(held_err));
          end
          held_data = bus.out_data;
          held_err  = bus.out_err;
        end
        nxt = err_clear ? 0 : model_cnt;
        if (bus.out_val && bus.out_rdy && sb.size() > 0) begin
          e = sb.pop_front();
          check("out_data", 128'(bus.out_data), 128'(e.data));
          check("out_err", 128'(bus.out_err), 128'(e.err));
          if (e.err && nxt < CNT_MAX) nxt++;
        end
        model_cnt = nxt;
        prev_val  = bus.out_val;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NBITS-1:0] w;
    logic             f;
    int               flips;

    reset_n     = 1'b0;
    bus.in_val  = 1'b0;
    bus.in_data = '0;
    bus.in_par  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_val", 128'(bus.out_val), 128'(0));
    check("rst_in_rdy", 128'(bus.in_rdy), 128'(1));
    check("rst_out_data", 128'(bus.out_data), 128'(0));
    check("rst_out_err", 128'(bus.out_err), 128'(0));
    check("rst_err_count", 128'(err_count), 128'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // All-zero word with matching parity.
    send_beats('0, 1'b0, NBEATS, 0);
    drain();
    cnt_check("cnt_after_zero", 0);

    // 0xA pattern has even weight; sending parity 1 must flag an error.
    w = {25{4'ha}};
    send_beats(w, 1'b1, NBEATS, 0);
    drain();
    cnt_check("cnt_after_aaaa", 1);
    w = '1;
    send_beats(w, 1'b0, NBEATS, 0);
    drain();
    cnt_check("cnt_after_ffff", 1);

    // Gaps between beats, 5-cycle consumer stall, and a second word queued behind it.
    sink_stall = 5;
    w = {25{4'h5}};
    send_beats(w, 1'b0, NBEATS, 3);
    w = rand_word();
    send_beats(w, ^w, NBEATS, 0);
    drain();
    sink_stall = 0;
    cnt_check("cnt_after_backpressure", 1);

    // Asynchronous reset in the middle of a word discards the partial beats.
    w = rand_word();
    send_beats(w, ~^w, 4, 0);
    #1;
    reset_n   = 1'b0;
    model_cnt = 0;
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    w = rand_word();
    send_beats(w, ^w, NBEATS, 0);
    drain();
    cnt_check("cnt_after_midword_reset", 0);

    // Drive the counter into saturation, then clear together with an errored handshake.
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      w = rand_word();
      send_beats(w, ~^w, NBEATS, 0);
    end
    drain();
    cnt_check("cnt_saturated", CNT_MAX);
    clear_on_hs = 1'b1;
    w = rand_word();
    send_beats(w, ~^w, NBEATS, 0);
    drain();
    cnt_check("cnt_clear_with_err_hs", 1);

    // Random words with randomly injected parity flips.
    clear_now = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    cnt_check("cnt_after_clear", 0);
    flips = 0;
    for (int i = 0; i < 20; i++) begin
      w = rand_word();
      f = 1'($urandom);
      flips += int'(f);
      sink_stall = int'($urandom_range(2, 0));
      send_beats(w, (^w) ^ f, NBEATS, 2);
    end
    drain();
    sink_stall = 0;
    cnt_check("cnt_equals_flips", flips);

    if (sb.size() != 0) fail_now("scoreboard_not_empty");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
